mm2s_dispatch: RTL

- Consumes the tag and data AXI-Stream pair that leave the MM2S prefetch buffer (buf2int data and tag streams).
- For each transfer it pops one tag and routes the following data burst to one of four on-chip consumer ports (weights, activations, bias, instructions).
- The burst runs until the data beat with tlast.
- Provides per-block status counters for the host.

---
 rtl/mm2s_dispatch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mm2s_dispatch.sv
// MM2S dispatcher: pops one tag per transfer and steers the following data
// burst (up to tlast) to one of four consumer ports, with host status counters.
`ifndef DFLT_CORE_AXI_DATA_WIDTH
`define DFLT_CORE_AXI_DATA_WIDTH 64
`endif
`ifndef DFLT_MEM_TAG_WIDTH
`define DFLT_MEM_TAG_WIDTH 8
`endif

module mm2s_dispatch #(
    parameter int AXI_DATA_WIDTH = `DFLT_CORE_AXI_DATA_WIDTH,
    parameter int TAG_WIDTH      = `DFLT_MEM_TAG_WIDTH,
    parameter int N_PORTS        = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        enable,
    output logic [2:0][31:0]                            status,
    output logic                                        busy,
    output logic [TAG_WIDTH-1:0]                        last_tag,
    output logic                                        s_axis_tag_tready,
    input  logic                                        s_axis_tag_tvalid,
    input  logic [TAG_WIDTH-1:0]                        s_axis_tag_tdata,
    input  logic [TAG_WIDTH/8-1:0]                      s_axis_tag_tkeep,
    input  logic                                        s_axis_tag_tlast,
    input  logic [1:0]                                  s_axis_tag_tdest,
    output logic                                        s_axis_tready,
    input  logic                                        s_axis_tvalid,
    input  logic [AXI_DATA_WIDTH-1:0]                   s_axis_tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]                 s_axis_tkeep,
    input  logic                                        s_axis_tlast,
    input  logic [1:0]                                  s_axis_tdest,
    input  logic [N_PORTS-1:0]                          m_axis_tready,
    output logic [N_PORTS-1:0]                          m_axis_tvalid,
    output logic [N_PORTS-1:0][AXI_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [N_PORTS-1:0][AXI_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [N_PORTS-1:0]                          m_axis_tlast
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [TAG_WIDTH-1:0] last_tag_q, last_tag_d;
    logic                 arm_q, arm_d;
    logic [31:0]          cnt_burst_q, cnt_burst_d;
    logic [31:0]          cnt_mis_q, cnt_mis_d;
    logic [31:0]          cnt_stall_q, cnt_stall_d;

    logic unused_tag_sideband;
    assign unused_tag_sideband = ^{s_axis_tag_tkeep, s_axis_tag_tlast, s_axis_tag_tdest};

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // arm_q holds tag_tready low for the first cycle out of reset
    always_comb begin
        state_d           = state_q;
        sel_d             = sel_q;
        last_tag_d        = last_tag_q;
        arm_d             = 1'b1;
        cnt_burst_d       = cnt_burst_q;
        cnt_mis_d         = cnt_mis_q;
        cnt_stall_d       = cnt_stall_q;
        s_axis_tag_tready = 1'b0;
        s_axis_tready     = 1'b0;
        m_axis_tvalid     = '0;
        busy              = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s_axis_tag_tready = enable & arm_q;
                if (s_axis_tag_tvalid && s_axis_tag_tready) begin
                    sel_d      = s_axis_tag_tdata[1:0];
                    last_tag_d = s_axis_tag_tdata;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy                 = 1'b1;
                m_axis_tvalid[sel_q] = s_axis_tvalid;
                s_axis_tready        = m_axis_tready[sel_q];
                if (s_axis_tvalid && s_axis_tready) begin
                    if (s_axis_tdest != sel_q)
                        cnt_mis_d = sat_inc(cnt_mis_q);
                    if (s_axis_tlast) begin
                        cnt_burst_d = sat_inc(cnt_burst_q);
                        state_d     = ST_IDLE;
                    end
                end
                if (s_axis_tvalid && !m_axis_tready[sel_q])
                    cnt_stall_d = sat_inc(cnt_stall_q);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            m_axis_tdata[p] = s_axis_tdata;
            m_axis_tkeep[p] = s_axis_tkeep;
            m_axis_tlast[p] = s_axis_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            last_tag_q  <= '0;
            arm_q       <= 1'b0;
            cnt_burst_q <= '0;
            cnt_mis_q   <= '0;
            cnt_stall_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_tag_q  <= last_tag_d;
            arm_q       <= arm_d;
            cnt_burst_q <= cnt_burst_d;
            cnt_mis_q   <= cnt_mis_d;
            cnt_stall_q <= cnt_stall_d;
        end
    end

    assign status[0] = cnt_burst_q;
    assign status[1] = cnt_mis_q;
    assign status[2] = cnt_stall_q;
    assign last_tag  = last_tag_q;

endmodule
